// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep sequencer: steps the oscillator frequency, gates the mean-current
// measurement window at each step and keeps the frequency giving the highest current.
module freq_sweep_ctrl #(
  parameter int                FREQ_W        = 16,
  parameter int                CUR_W         = 12,
  parameter int                SETTLE_CYCLES = 1000,
  parameter int                MEAS_CYCLES   = 40000,
  parameter logic [FREQ_W-1:0] FREQ_MIN      = 16'd100,
  parameter logic [FREQ_W-1:0] FREQ_STEP     = 16'd10,
  parameter int                NUM_STEPS     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              swiptAlive,
  input  logic              start,
  input  logic [CUR_W-1:0]  mean_curr,
  output logic              measure,
  output logic [FREQ_W-1:0] freq,
  output logic              busy,
  output logic              done,
  output logic [FREQ_W-1:0] best_freq,
  output logic [CUR_W-1:0]  best_curr
);

  localparam int CNT_MAX  = (SETTLE_CYCLES > MEAS_CYCLES) ? SETTLE_CYCLES : MEAS_CYCLES;
  localparam int CNT_BITS = $clog2(CNT_MAX + 1);
  localparam int CNT_W    = (CNT_BITS > 20) ? CNT_BITS : 20;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_CYCLES - 1);
  localparam logic [15:0]      LAST_STEP   = 16'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CUR_W-1:0] CUR_ZERO    = {CUR_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_STEP    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [15:0]       step_r;
  logic [15:0]       step_next_s;
  logic [FREQ_W-1:0] freq_r;
  logic [FREQ_W-1:0] freq_next_s;
  logic [FREQ_W-1:0] best_freq_r;
  logic [FREQ_W-1:0] best_freq_next_s;
  logic [CUR_W-1:0]  best_curr_r;
  logic [CUR_W-1:0]  best_curr_next_s;
  logic              measure_r;
  logic              measure_next_s;
  logic              busy_r;
  logic              busy_next_s;
  logic              done_r;
  logic              done_next_s;
  logic              abort_s;
  logic              launch_s;

  // A dead link kills any sweep in progress; a start only counts in IDLE with the link up.
  assign abort_s  = (state_r != ST_IDLE) && !swiptAlive;
  assign launch_s = (state_r == ST_IDLE) && start && swiptAlive;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    if (abort_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            state_next_s = ST_SETTLE;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            state_next_s = ST_MEASURE;
          end else begin
            state_next_s = ST_SETTLE;
          end
        end
        ST_MEASURE: begin
          if (cnt_r == MEAS_LAST) begin
            state_next_s = ST_CAPTURE;
          end else begin
            state_next_s = ST_MEASURE;
          end
        end
        ST_CAPTURE: begin
          if (step_r == LAST_STEP) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_STEP;
          end
        end
        ST_STEP:  state_next_s = ST_SETTLE;
        ST_DONE:  state_next_s = ST_IDLE;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: counters, frequency word and best-so-far tracking.
  always_comb begin
    cnt_next_s       = cnt_r;
    step_next_s      = step_r;
    freq_next_s      = freq_r;
    best_freq_next_s = best_freq_r;
    best_curr_next_s = best_curr_r;
    if (abort_s) begin
      cnt_next_s       = CNT_ZERO;
      step_next_s      = 16'd0;
      freq_next_s      = FREQ_MIN;
      best_freq_next_s = FREQ_MIN;
      best_curr_next_s = CUR_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            cnt_next_s       = CNT_ZERO;
            step_next_s      = 16'd0;
            freq_next_s      = FREQ_MIN;
            best_freq_next_s = FREQ_MIN;
            best_curr_next_s = CUR_ZERO;
          end else begin
            cnt_next_s = cnt_r;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            cnt_next_s = CNT_ZERO;
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end
        ST_MEASURE: begin
          if (cnt_r == MEAS_LAST) begin
            cnt_next_s = CNT_ZERO;
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end
        ST_CAPTURE: begin
          cnt_next_s = CNT_ZERO;
          // Strict compare: on a tie the earlier (lower) frequency is kept.
          if (mean_curr > best_curr_r) begin
            best_curr_next_s = mean_curr;
            best_freq_next_s = freq_r;
          end else begin
            best_curr_next_s = best_curr_r;
          end
        end
        ST_STEP: begin
          cnt_next_s  = CNT_ZERO;
          freq_next_s = freq_r + FREQ_STEP;
          step_next_s = step_r + 16'd1;
        end
        ST_DONE: begin
          cnt_next_s  = CNT_ZERO;
          freq_next_s = best_freq_r;
        end
        default: begin
          cnt_next_s  = CNT_ZERO;
          step_next_s = 16'd0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the flags line up with it once registered.
  always_comb begin
    measure_next_s = (state_next_s == ST_MEASURE);
    busy_next_s    = (state_next_s != ST_IDLE);
    done_next_s    = (state_next_s == ST_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= CNT_ZERO;
      step_r      <= 16'd0;
      freq_r      <= FREQ_MIN;
      best_freq_r <= FREQ_MIN;
      best_curr_r <= CUR_ZERO;
      measure_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cnt_r       <= cnt_next_s;
      step_r      <= step_next_s;
      freq_r      <= freq_next_s;
      best_freq_r <= best_freq_next_s;
      best_curr_r <= best_curr_next_s;
      measure_r   <= measure_next_s;
      busy_r      <= busy_next_s;
      done_r      <= done_next_s;
    end
  end

  assign measure   = measure_r;
  assign freq      = freq_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign best_freq = best_freq_r;
  assign best_curr = best_curr_r;

endmodule
